// File: rtl/prio_req_encoder_pkg.sv
// prio_req_encoder_pkg: FSM state type and index width helper for the priority request encoder
package prio_req_encoder_pkg;

   typedef enum logic {IDLE, PRESENT} state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prio_find_hi.sv
// prio_find_hi: combinational search for the highest set bit of a vector
module prio_find_hi
   import prio_req_encoder_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = idx_w(N)
) (
   input  logic [N-1:0] vec_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   // ascending scan so the last (highest) set bit overwrites lower ones
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = 0; i < N; i++) begin
         if (vec_i[i]) begin
            found_o = 1'b1;
            idx_o   = W'(i);
         end
      end
   end

endmodule

// File: rtl/prio_req_encoder.sv
// prio_req_encoder: registered priority encoder with sticky pending requests, mask and valid/ready output
// Optional rotating priority is enabled by defining PRIO_REQ_ENCODER_RR_EN.
module prio_req_encoder
   import prio_req_encoder_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = idx_w(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] mask_i,
   input  logic         out_ready_i,
   output logic         out_valid_o,
   output logic [W-1:0] out_idx_o,
   output logic [N-1:0] pending_o,
   output logic         any_pending_o
);

   state_e       state_q, state_d;
   logic [N-1:0] pending_q, pending_d, sel, clr;
   logic         valid_q, valid_d, any_q, found;
   logic [W-1:0] idx_q, idx_d, pick;

   assign sel = pending_q & ~mask_i;

`ifdef PRIO_REQ_ENCODER_RR_EN
   logic [W-1:0] last_q, last_d, rot_idx;
   logic [N-1:0] rot;
   logic [W:0]   sum;

   // rotate so last_q lands on bit 0 (lowest priority) and last_q-1 on bit N-1
   assign rot    = N'({sel, sel} >> last_q);
   prio_find_hi #(.N(N)) u_find (.vec_i(rot), .found_o(found), .idx_o(rot_idx));
   assign sum    = {1'b0, rot_idx} + {1'b0, last_q};
   assign pick   = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
   assign last_d = (valid_q && out_ready_i) ? idx_q : last_q;

   // rotating pointer remembers the most recently granted index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= W'(N-1);
      else        last_q <= last_d;
   end
`else
   prio_find_hi #(.N(N)) u_find (.vec_i(sel), .found_o(found), .idx_o(pick));
`endif

   // select in IDLE, hold in PRESENT until the consumer accepts
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      clr     = '0;
      if (state_q == IDLE && found) begin
         state_d = PRESENT;
         valid_d = 1'b1;
         idx_d   = pick;
      end else if (state_q == PRESENT && out_ready_i) begin
         state_d = IDLE;
         valid_d = 1'b0;
         idx_d   = '0;
         clr     = N'(1) << idx_q;
      end
   end

   // new requests are applied after the clear so a same-cycle set wins
   assign pending_d = (pending_q & ~clr) | req_i;

   // state, selection, pending and summary registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         pending_q <= '0;
         any_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         any_q     <= |sel;
      end
   end

   assign out_valid_o   = valid_q;
   assign out_idx_o     = idx_q;
   assign pending_o     = pending_q;
   assign any_pending_o = any_q;

endmodule

// File: tb/tb_prio_req_encoder.sv
// tb_prio_req_encoder: directed scenarios plus random stimulus checked against a per-cycle reference model
module tb_prio_req_encoder;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] mask = '0;
   logic         ready = 1'b0;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] pending;
   logic         any_pending;

   int checks = 0;
   int failures = 0;

   bit m_pend[N];
   bit m_valid;
   int m_idx;
   int m_last;
   bit m_any;
   int grants[$];
   int exp_q[$];

   prio_req_encoder #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .mask_i(mask), .out_ready_i(ready),
      .out_valid_o(out_valid), .out_idx_o(out_idx), .pending_o(pending), .any_pending_o(any_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int m_pend_vec();
      int v = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_last  = N - 1;
      m_any   = 1'b0;
   endtask

   // one clock edge of the reference behaviour
   task automatic m_step(input logic [N-1:0] r, input logic [N-1:0] m, input bit rdy);
      bit nxt[N];
      bit any = 1'b0;
      for (int i = 0; i < N; i++) if (m_pend[i] && !m[i]) any = 1'b1;
      nxt = m_pend;
      if (m_valid) begin
         if (rdy) begin
            nxt[m_idx] = 1'b0;
            m_last     = m_idx;
            m_valid    = 1'b0;
            m_idx      = 0;
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            int i;
`ifdef PRIO_REQ_ENCODER_RR_EN
            i = (m_last - k + N) % N;
`else
            i = N - k;
`endif
            if (m_pend[i] && !m[i]) begin
               m_valid = 1'b1;
               m_idx   = i;
               break;
            end
         end
      end
      for (int i = 0; i < N; i++) if (r[i]) nxt[i] = 1'b1;
      m_pend = nxt;
      m_any  = any;
   endtask

   task automatic compare();
      check("valid", out_valid, m_valid);
      check("idx", out_idx, m_idx);
      check("pending", pending, m_pend_vec());
      check("any", any_pending, m_any);
   endtask

   // called at a falling edge: drive, record a DUT grant, clock, compare
   task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] m, input bit rdy);
      req   = r;
      mask  = m;
      ready = rdy;
      if (out_valid === 1'b1 && rdy) grants.push_back(int'(out_idx));
      @(posedge clk);
      m_step(r, m, rdy);
      @(negedge clk);
      compare();
   endtask

   task automatic expect_grants(input string tag);
      check({tag, "_count"}, grants.size() >= exp_q.size(), 1);
      for (int i = 0; i < exp_q.size(); i++)
         check(tag, (i < grants.size()) ? grants[i] : -1, exp_q[i]);
      grants.delete();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 m_reset();
      compare();
      @(negedge clk);
      rst_n = 1'b1;
      compare();
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      compare();
      rst_n = 1'b1;

      cyc(8'h24, 8'h00, 1'b1);
      repeat (6) cyc(8'h00, 8'h00, 1'b1);
      exp_q = {5, 2};
      expect_grants("two_req");
      check("two_req_pend", pending, 0);

      cyc(8'h40, 8'h00, 1'b0);
      cyc(8'h00, 8'h00, 1'b0);
      repeat (5) cyc(8'h80, 8'h00, 1'b0);
      check("stable_idx", out_idx, 6);
      repeat (6) cyc(8'h00, 8'h00, 1'b1);
      exp_q = {6, 7};
      expect_grants("stable");

      cyc(8'hFF, 8'hF0, 1'b1);
      repeat (9) cyc(8'h00, 8'hF0, 1'b1);
      exp_q = {3, 2, 1, 0};
      expect_grants("mask_lo");
      check("mask_kept", pending, 8'hF0);
      repeat (9) cyc(8'h00, 8'h00, 1'b1);
      exp_q = {7, 6, 5, 4};
      expect_grants("mask_hi");

      cyc(8'h10, 8'h00, 1'b0);
      cyc(8'h00, 8'h00, 1'b0);
      cyc(8'h10, 8'h00, 1'b1);
      check("setwins_pend", pending[4], 1);
      repeat (4) cyc(8'h00, 8'h00, 1'b1);
      exp_q = {4, 4};
      expect_grants("setwins");

      repeat (9) cyc(8'h81, 8'h00, 1'b1);
`ifdef PRIO_REQ_ENCODER_RR_EN
      exp_q = {0, 7, 0, 7};
`else
      exp_q = {7, 7, 7, 7};
`endif
      expect_grants("persist");
      repeat (6) cyc(8'h00, 8'h00, 1'b1);
      grants.delete();

      cyc(8'h0C, 8'h00, 1'b0);
      cyc(8'h00, 8'h00, 1'b0);
      check("pre_reset_valid", out_valid, 1);
      async_reset();

      repeat (3000) begin
         logic [N-1:0] r, m;
         r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         if ($urandom_range(0, 499) == 0) async_reset();
         cyc(r, m, 1'($urandom_range(0, 1)));
      end
      grants.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
